alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU. Captures the ALU result and its 3-bit compare code along with the instruction's destination and control bits.
- Maintains the architectural compare-flags register and resolves conditional branches against it.
- Presents results to writeback through a 2-entry skid buffer with a valid/ready handshake on both sides.

Parameters:
- DATA_W, 16, width of the ALU result.
- RD_W, 3, width of the destination register index.
- CNT_W, 8, width of the retired-result counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_result  in  DATA_W  ALU out.
- in_comp  in  3  ALU comp code: 100 = greater (signed), 010 = equal, 001 = less.
- in_rd  in  RD_W  destination register index.
- in_wen  in  1  entry writes the register file.
- in_setflags  in  1  entry updates the flags register.
- in_is_branch  in  1  entry is a conditional branch.
- in_cond  in  3  branch condition mask, same bit positions as comp.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts the head entry.
- out_result  out  DATA_W  head result.
- out_rd  out  RD_W  head destination.
- out_wen  out  1  head write enable.
- out_taken  out  1  head branch resolved taken.
- flags  out  3  current flags register.
- retired  out  CNT_W  count of output handshakes.

Behaviour:
- Reset (async, rst_n = 0): out_valid = 0, skid empty, in_ready = 1, flags = 000, retired = 0. Data outputs are 0.
- Reset mid-operation discards both entries immediately. There is no partial drain.
- Accept: in_valid && in_ready at a clk edge.
- Retire: out_valid && out_ready at a clk edge.
- Storage: a main register drives the out_* ports; a skid register holds one more entry.
- in_ready = !skid_full. It is a registered signal with no combinational path from out_ready.
- Occupancy rules per edge:
  - Empty + accept: entry goes to main. out_valid = 1 on the next cycle (1-cycle latency).
  - Main full + retire + accept, skid empty: new entry replaces main.
  - Main full + no retire + accept: entry goes to skid. in_ready = 0 next cycle.
  - Skid full + retire: skid moves to main. Skid empties and in_ready = 1 next cycle.
  - Skid full + no retire: everything holds. in_ready stays 0.
- Entries retire strictly in accept order. No entry is ever dropped or duplicated.
- Branch resolution happens at accept time:
  - taken = in_is_branch && |(in_cond & flags), using the flags value before this edge.
  - taken is stored with the entry and presented as out_taken.
  - For a non-branch entry, taken = 0.
- Flags update at accept time:
  - If in_setflags, flags <= in_comp on that edge, independent of downstream stall.
  - An entry with both in_is_branch and in_setflags evaluates against the old flags, then updates them.
- in_comp values outside {100, 010, 001} are stored verbatim. No checking is done.
- retired increments by 1 on each retire and wraps from 2^CNT_W-1 to 0.
- When out_valid = 0, out_* data hold their last value and must be ignored by the consumer.

Decomposition:
- Shared package alu_pkg holds:
  - COMP_GT = 3'b100, COMP_EQ = 3'b010, COMP_LT = 3'b001.
  - DATA_W default.
  - The ALU op codes (ADD..DIV, 4 bits).
- One sub-module: skid_buffer_2 (generic 2-entry valid/ready buffer, parameterised by payload width).
  - Payload is {result, rd, wen, taken}.
- Flags register, branch resolution and the retired counter stay in the top module.

Test Plan:
- Reset with rst_n = 0 mid-stream (2 entries held) -> out_valid = 0, in_ready = 1, flags = 000, retired = 0 immediately, before any clk edge.
- Single entry, result = 16'h1234, rd = 5, wen = 1, out_ready = 1 -> next cycle out_valid = 1, out_result = 1234, out_rd = 5. Following cycle retired = 1.
- out_ready = 0, accept A = 0x0001 then B = 0x0002 -> in_ready = 0 after B. A third entry is not accepted. Raising out_ready retires A then B in order, then in_ready = 1.
- setflags entry with comp = 100, then branch cond = 100 -> out_taken = 1. Branch cond = 011 -> out_taken = 0.
- One entry with setflags = 1, comp = 010 and is_branch = 1, cond = 010, with prior flags = 001 -> out_taken = 0. flags = 010 afterwards.
- 256 back-to-back retires with out_ready = 1 -> retired wraps to 0 and throughput is 1 per cycle with in_ready held at 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Purpose  : shared ALU definitions: compare codes, default datapath width,
//            op codes and the branch-resolution helper.
// Latency  : n/a (package, no logic of its own)
// Backpress: n/a
package alu_pkg;

   // Compare code produced by the ALU alongside every result. Exactly one bit
   // is set for a well-formed compare; other patterns pass through untouched.
   localparam logic [2:0] COMP_GT = 3'b100;  // greater (signed)
   localparam logic [2:0] COMP_EQ = 3'b010;  // equal
   localparam logic [2:0] COMP_LT = 3'b001;  // less

   localparam int DATA_W_DEF = 16;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SHL = 4'd5,
      ALU_SHR = 4'd6,
      ALU_CMP = 4'd7,
      ALU_MUL = 4'd8,
      ALU_DIV = 4'd9
   } alu_op_t;

   // A branch is taken when any condition bit lines up with a set flag bit,
   // so cond = GT|EQ expresses "greater or equal" and so on.
   function automatic logic resolve_taken(input logic       is_branch,
                                          input logic [2:0] cond,
                                          input logic [2:0] flags);
      return is_branch && (|(cond & flags));
   endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Purpose  : generic 2-entry valid/ready buffer (main register + skid register).
// Latency  : 1 cycle from accept to out_vld; full throughput when out_rdy held high.
// Backpress: in_rdy = !skid_full, registered; no combinational path from out_rdy.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_vld/in_rdy/in_dat  upstream handshake and payload
//   out_vld/out_rdy/out_dat  downstream handshake and payload (driven by main reg)
module skid_buffer_2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat
);

   logic         main_vld_q, main_vld_d;
   logic [W-1:0] main_dat_q, main_dat_d;
   logic         skid_vld_q, skid_vld_d;
   logic [W-1:0] skid_dat_q, skid_dat_d;

   logic accept;
   logic retire;

   assign in_rdy  = !skid_vld_q;
   assign out_vld = main_vld_q;
   assign out_dat = main_dat_q;

   assign accept = in_vld && !skid_vld_q;
   assign retire = main_vld_q && out_rdy;

   // The skid register can only be occupied while main is occupied, so the
   // three branches below cover every legal occupancy.
   always_comb begin
      main_vld_d = main_vld_q;
      main_dat_d = main_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;

      if (skid_vld_q) begin
         // Full: nothing can be accepted; a retire shifts skid into main.
         if (retire) begin
            main_dat_d = skid_dat_q;
            skid_vld_d = 1'b0;
         end
      end else if (main_vld_q) begin
         if (retire && accept) begin
            main_dat_d = in_dat;
         end else if (retire) begin
            main_vld_d = 1'b0;
         end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat;
         end
      end else if (accept) begin
         main_vld_d = 1'b1;
         main_dat_d = in_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_q <= 1'b0;
         main_dat_q <= '0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         main_dat_q <= main_dat_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Purpose  : ALU result stage: compare-flags register, branch resolution at
//            accept, retired-result counter, 2-entry skid buffer to writeback.
// Latency  : 1 cycle accept -> out_valid; 1 result per cycle sustained.
// Backpress: in_ready = !skid_full (registered); holds everything when full and stalled.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready                   upstream handshake
//   in_result, in_comp                  ALU result and compare code
//   in_rd, in_wen                       destination index and write enable
//   in_setflags, in_is_branch, in_cond  flag update, branch and condition mask
//   out_valid/out_ready                 writeback handshake
//   out_result, out_rd, out_wen, out_taken  head entry
//   flags                               architectural compare flags
//   retired                             wrapping count of output handshakes
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [2:0]        in_comp,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_wen,
   input  logic              in_setflags,
   input  logic              in_is_branch,
   input  logic [2:0]        in_cond,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_wen,
   output logic              out_taken,
   output logic [2:0]        flags,
   output logic [CNT_W-1:0]  retired
);

   localparam int PAY_W = DATA_W + RD_W + 2;

   logic [2:0]       flags_q, flags_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic             accept;
   logic             retire;
   logic             in_taken;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] out_pay;

   assign accept = in_valid && in_ready;
   assign retire = out_valid && out_ready;

   // Resolved against the flags as they stand before this edge, so an entry
   // that both branches and sets flags sees the older compare result.
   assign in_taken = resolve_taken(in_is_branch, in_cond, flags_q);
   assign in_pay   = {in_result, in_rd, in_wen, in_taken};

   skid_buffer_2 #(
      .W (PAY_W)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (in_valid),
      .in_rdy  (in_ready),
      .in_dat  (in_pay),
      .out_vld (out_valid),
      .out_rdy (out_ready),
      .out_dat (out_pay)
   );

   assign {out_result, out_rd, out_wen, out_taken} = out_pay;

   // Flags move at accept, not at retire: a later entry can be accepted into
   // the skid register while the head is stalled and must see this update.
   always_comb begin
      flags_d   = flags_q;
      retired_d = retired_q;
      if (accept && in_setflags) begin
         flags_d = in_comp;
      end
      if (retire) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q   <= 3'b000;
         retired_q <= '0;
      end else begin
         flags_q   <= flags_d;
         retired_q <= retired_d;
      end
   end

   assign flags   = flags_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Purpose  : directed self-checking bench for alu_result_stage.
// Latency  : inputs change 1 time unit after a rising edge; outputs sampled there too.
// Backpress: bench drives out_ready directly to create stalls.
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [2:0]  in_comp;
   logic [2:0]  in_rd;
   logic        in_wen;
   logic        in_setflags;
   logic        in_is_branch;
   logic [2:0]  in_cond;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_rd;
   logic        out_wen;
   logic        out_taken;
   logic [2:0]  flags;
   logic [7:0]  retired;

   int vectors;
   int miscompares;

   alu_result_stage #(
      .DATA_W (16),
      .RD_W   (3),
      .CNT_W  (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_comp      (in_comp),
      .in_rd        (in_rd),
      .in_wen       (in_wen),
      .in_setflags  (in_setflags),
      .in_is_branch (in_is_branch),
      .in_cond      (in_cond),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_rd       (out_rd),
      .out_wen      (out_wen),
      .out_taken    (out_taken),
      .flags        (flags),
      .retired      (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] res, input logic [2:0] comp,
                        input logic [2:0] rd, input logic wen, input logic sf,
                        input logic br, input logic [2:0] cond);
      in_valid     = v;
      in_result    = res;
      in_comp      = comp;
      in_rd        = rd;
      in_wen       = wen;
      in_setflags  = sf;
      in_is_branch = br;
      in_cond      = cond;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic test_reset();
      idle();
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", flags); end
      vectors++; if (retired !== 8'd0) begin miscompares++; $display("FAIL reset_retired got %0d want 0", retired); end
      vectors++; if (out_result !== 16'h0000) begin miscompares++; $display("FAIL reset_out_result got %h want 0000", out_result); end
      #20;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      drive(1'b1, 16'h1234, 3'b000, 3'd5, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      idle();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
      vectors++; if (out_result !== 16'h1234) begin miscompares++; $display("FAIL single_result got %h want 1234", out_result); end
      vectors++; if (out_rd !== 3'd5) begin miscompares++; $display("FAIL single_rd got %0d want 5", out_rd); end
      vectors++; if (out_wen !== 1'b1) begin miscompares++; $display("FAIL single_wen got %b want 1", out_wen); end
      vectors++; if (out_taken !== 1'b0) begin miscompares++; $display("FAIL single_taken got %b want 0", out_taken); end
      vectors++; if (retired !== 8'd0) begin miscompares++; $display("FAIL single_retired_pre got %0d want 0", retired); end
      tick();
      vectors++; if (retired !== 8'd1) begin miscompares++; $display("FAIL single_retired got %0d want 1", retired); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 16'h0001, 3'b000, 3'd1, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after_a got %b want 1", in_ready); end
      drive(1'b1, 16'h0002, 3'b000, 3'd2, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_after_b got %b want 0", in_ready); end
      vectors++; if (out_result !== 16'h0001) begin miscompares++; $display("FAIL bp_head_a got %h want 0001", out_result); end
      // Offered while full; must never appear downstream.
      drive(1'b1, 16'h0003, 3'b000, 3'd3, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready got %b want 0", in_ready); end
      vectors++; if (out_result !== 16'h0001) begin miscompares++; $display("FAIL bp_hold_head got %h want 0001", out_result); end
      idle();
      out_ready = 1'b1;
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_b_valid got %b want 1", out_valid); end
      vectors++; if (out_result !== 16'h0002) begin miscompares++; $display("FAIL bp_b_result got %h want 0002", out_result); end
      vectors++; if (out_rd !== 3'd2) begin miscompares++; $display("FAIL bp_b_rd got %0d want 2", out_rd); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_restored got %b want 1", in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_third got %b want 0", out_valid); end
      vectors++; if (retired !== 8'd3) begin miscompares++; $display("FAIL bp_retired got %0d want 3", retired); end
   endtask

   task automatic test_branch();
      out_ready = 1'b1;
      drive(1'b1, 16'h0010, 3'b100, 3'd0, 1'b0, 1'b1, 1'b0, 3'b000);
      tick();
      vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL br_flags got %b want 100", flags); end
      vectors++; if (out_taken !== 1'b0) begin miscompares++; $display("FAIL br_nonbranch_taken got %b want 0", out_taken); end
      drive(1'b1, 16'h0011, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 3'b100);
      tick();
      vectors++; if (out_taken !== 1'b1) begin miscompares++; $display("FAIL br_gt_taken got %b want 1", out_taken); end
      vectors++; if (out_result !== 16'h0011) begin miscompares++; $display("FAIL br_gt_result got %h want 0011", out_result); end
      drive(1'b1, 16'h0012, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 3'b011);
      tick();
      vectors++; if (out_taken !== 1'b0) begin miscompares++; $display("FAIL br_le_taken got %b want 0", out_taken); end
      idle();
      tick();
   endtask

   task automatic test_branch_setflags();
      out_ready = 1'b1;
      drive(1'b1, 16'h0020, 3'b001, 3'd0, 1'b0, 1'b1, 1'b0, 3'b000);
      tick();
      vectors++; if (flags !== 3'b001) begin miscompares++; $display("FAIL bsf_prior_flags got %b want 001", flags); end
      drive(1'b1, 16'h0021, 3'b010, 3'd0, 1'b0, 1'b1, 1'b1, 3'b010);
      tick();
      vectors++; if (out_taken !== 1'b0) begin miscompares++; $display("FAIL bsf_old_flags_taken got %b want 0", out_taken); end
      vectors++; if (flags !== 3'b010) begin miscompares++; $display("FAIL bsf_new_flags got %b want 010", flags); end
      drive(1'b1, 16'h0022, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 3'b010);
      tick();
      vectors++; if (out_taken !== 1'b1) begin miscompares++; $display("FAIL bsf_eq_taken got %b want 1", out_taken); end
      idle();
      tick();
      vectors++; if (retired !== 8'd9) begin miscompares++; $display("FAIL bsf_retired got %0d want 9", retired); end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 3'b100, 3'd6, 1'b1, 1'b1, 1'b0, 3'b000);
      tick();
      drive(1'b1, 16'hBBBB, 3'b001, 3'd7, 1'b1, 1'b0, 1'b0, 3'b000);
      tick();
      idle();
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_pre_full got %b want 0", in_ready); end
      vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL mid_pre_flags got %b want 100", flags); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b want 1", in_ready); end
      vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL mid_flags got %b want 000", flags); end
      vectors++; if (retired !== 8'd0) begin miscompares++; $display("FAIL mid_retired got %0d want 0", retired); end
      #20;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_drain got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 16'(i) ^ 16'h5A00, 3'b000, 3'(i), 1'b1, 1'b0, 1'b0, 3'b000);
         tick();
         vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
         vectors++; if (out_result !== (16'(i) ^ 16'h5A00)) begin miscompares++; $display("FAIL b2b_result[%0d] got %h want %h", i, out_result, 16'(i) ^ 16'h5A00); end
         vectors++; if (retired !== 8'(i)) begin miscompares++; $display("FAIL b2b_retired[%0d] got %0d want %0d", i, retired, i); end
      end
      idle();
      tick();
      vectors++; if (retired !== 8'd0) begin miscompares++; $display("FAIL b2b_wrap got %0d want 0", retired); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got %b want 0", out_valid); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_backpressure();
      test_branch();
      test_branch_setflags();
      test_reset_midstream();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
